// File: rtl/fsk_demodulator.sv
// Binary FSK demodulator: measures the spacing of rising zero crossings of a sampled sine,
// classifies each period as the high (short) or low (long) tone and confirms before switching.
module fsk_demodulator #(
   parameter int unsigned SAMPLE_WIDTH     = 32,
   parameter int unsigned PERIOD_WIDTH     = 16,
   parameter int unsigned PERIOD_MIN       = 4,
   parameter int unsigned PERIOD_THRESHOLD = 60,
   parameter int unsigned PERIOD_MAX       = 200,
   parameter int unsigned CONFIRM_COUNT    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sine_in,
   output logic                    data_out,
   output logic                    data_valid,
   output logic [PERIOD_WIDTH-1:0] period_out,
   output logic                    tone_class,
   output logic                    carrier_lock
);

   localparam int unsigned RunWidth = $clog2(CONFIRM_COUNT + 1);

   localparam logic [PERIOD_WIDTH-1:0] CntMin = PERIOD_WIDTH'(PERIOD_MIN);
   localparam logic [PERIOD_WIDTH-1:0] CntThr = PERIOD_WIDTH'(PERIOD_THRESHOLD);
   localparam logic [PERIOD_WIDTH-1:0] CntMax = PERIOD_WIDTH'(PERIOD_MAX);
   localparam logic [PERIOD_WIDTH-1:0] CntOne = PERIOD_WIDTH'(1);
   localparam logic [RunWidth-1:0]     RunMax = RunWidth'(CONFIRM_COUNT);
   localparam logic [RunWidth-1:0]     RunOne = RunWidth'(1);

   typedef enum logic [0:0] {StAcquire, StTrack} state_e;

   state_e                  state_q, state_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic [RunWidth-1:0]     run_q, run_d;
   logic                    sign_q, sign_dly_q;
   logic                    rise;
   logic                    new_class;
   logic                    valid_d, class_d, data_d, lock_d;
   logic [PERIOD_WIDTH-1:0] period_d;

   // Only the sign bit takes part in zero-crossing detection.
   logic unused_sample_bits;
   assign unused_sample_bits = ^sine_in[SAMPLE_WIDTH-2:0];

   assign rise      = sign_dly_q & ~sign_q;
   assign new_class = (cnt_q < CntThr);

   always_comb begin
      state_d  = state_q;
      cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      run_d    = run_q;
      valid_d  = 1'b0;
      period_d = period_out;
      class_d  = tone_class;
      data_d   = data_out;
      lock_d   = carrier_lock;
      unique case (state_q)
         StAcquire: begin
            if (rise) begin
               cnt_d   = CntOne;
               run_d   = '0;
               state_d = StTrack;
            end
         end
         StTrack: begin
            if (rise && (cnt_q >= CntMin)) begin
               period_d = cnt_q;
               valid_d  = 1'b1;
               class_d  = new_class;
               cnt_d    = CntOne;
               // run==0 means no accepted period yet since acquisition.
               if ((run_q != '0) && (new_class == tone_class)) begin
                  run_d = (run_q == RunMax) ? run_q : run_q + RunOne;
               end else begin
                  run_d = RunOne;
               end
               if (run_d == RunMax) begin
                  lock_d = 1'b1;
                  data_d = new_class;
               end
            end else if (!rise && (cnt_q == CntMax)) begin
               state_d = StAcquire;
               lock_d  = 1'b0;
               run_d   = '0;
            end
         end
         default: state_d = StAcquire;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StAcquire;
         cnt_q        <= '0;
         run_q        <= '0;
         sign_q       <= 1'b0;
         sign_dly_q   <= 1'b0;
         data_out     <= 1'b0;
         data_valid   <= 1'b0;
         period_out   <= '0;
         tone_class   <= 1'b0;
         carrier_lock <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         run_q        <= run_d;
         sign_q       <= sine_in[SAMPLE_WIDTH-1];
         sign_dly_q   <= sign_q;
         data_out     <= data_d;
         data_valid   <= valid_d;
         period_out   <= period_d;
         tone_class   <= class_d;
         carrier_lock <= lock_d;
      end
   end

endmodule

// File: tb/tb_fsk_demodulator.sv
// Directed bench for fsk_demodulator: synthetic periods with a fixed 3-sample positive tail,
// so each rising crossing sits exactly one period after the previous one.
module tb_fsk_demodulator;

   localparam logic [31:0] NEG = 32'hFFFF_FC18;  // -1000
   localparam logic [31:0] POS = 32'd1000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] sine_in;
   logic        data_out;
   logic        data_valid;
   logic [15:0] period_out;
   logic        tone_class;
   logic        carrier_lock;

   int checks = 0;
   int errors = 0;

   int          pulses = 0;
   logic [15:0] cap_period = '0;
   logic        cap_class = 1'b0;
   logic        cap_data = 1'b0;
   logic        cap_lock = 1'b0;

   fsk_demodulator dut (
      .clk         (clk),
      .reset       (reset),
      .sine_in     (sine_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .period_out  (period_out),
      .tone_class  (tone_class),
      .carrier_lock(carrier_lock)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_valid) begin
         pulses     = pulses + 1;
         cap_period = period_out;
         cap_class  = tone_class;
         cap_data   = data_out;
         cap_lock   = carrier_lock;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // n-3 negative samples then 3 non-negative ones; the pulse for this rise lands inside.
   task automatic drive_period(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sine_in = (i < n - 3) ? NEG : POS;
      end
      #1;
   endtask

   task automatic no_pulse_period(input string tag, input int n, input logic lck);
      int p0;
      p0 = pulses;
      drive_period(n);
      check_eq({tag, "_pulses"}, pulses - p0, 0);
      check_eq({tag, "_lock"}, carrier_lock, lck);
   endtask

   task automatic pulse_period(input string tag, input int n, input logic [15:0] per,
                               input logic cls, input logic dat, input logic lck);
      int p0;
      p0 = pulses;
      drive_period(n);
      check_eq({tag, "_pulses"}, pulses - p0, 1);
      check_eq({tag, "_period"}, cap_period, per);
      check_eq({tag, "_class"}, cap_class, cls);
      check_eq({tag, "_data"}, cap_data, dat);
      check_eq({tag, "_lock"}, cap_lock, lck);
   endtask

   initial begin
      reset   = 1'b1;
      sine_in = '0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_data", data_out, 0);
      check_eq("rst_valid", data_valid, 0);
      check_eq("rst_period", period_out, 0);
      check_eq("rst_class", tone_class, 0);
      check_eq("rst_lock", carrier_lock, 0);
      @(negedge clk);
      reset = 1'b0;

      repeat (500) @(negedge clk);
      #1;
      check_eq("idle_pulses", pulses, 0);
      check_eq("idle_lock", carrier_lock, 0);
      check_eq("idle_period", period_out, 0);
      check_eq("idle_data", data_out, 0);

      // Low tone acquisition and lock
      no_pulse_period("acq", 100, 1'b0);
      pulse_period("low1", 100, 16'd100, 1'b0, 1'b0, 1'b0);
      pulse_period("low2", 100, 16'd100, 1'b0, 1'b0, 1'b1);
      // Switch to high tone: second short period flips data
      pulse_period("hi1", 20, 16'd20, 1'b1, 1'b0, 1'b1);
      pulse_period("hi2", 20, 16'd20, 1'b1, 1'b1, 1'b1);
      pulse_period("lo_back1", 100, 16'd100, 1'b0, 1'b1, 1'b1);
      pulse_period("lo_back2", 100, 16'd100, 1'b0, 1'b0, 1'b1);
      // Single short period inside low tone
      pulse_period("ins_short", 20, 16'd20, 1'b1, 1'b0, 1'b1);
      pulse_period("ins_low1", 100, 16'd100, 1'b0, 1'b0, 1'b1);
      pulse_period("ins_low2", 100, 16'd100, 1'b0, 1'b0, 1'b1);

      // Glitch: valid rise at 97 then a second rise 2 cycles later that must be ignored
      begin
         int p0;
         p0 = pulses;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            sine_in = (i < 97 || i == 98) ? NEG : POS;
         end
         #1;
         check_eq("glitch_pulses", pulses - p0, 1);
         check_eq("glitch_period", cap_period, 100);
      end
      pulse_period("post_glitch", 100, 16'd100, 1'b0, 1'b0, 1'b1);

      // Threshold, minimum and saturation boundaries
      pulse_period("thr59", 59, 16'd59, 1'b1, 1'b0, 1'b1);
      pulse_period("thr60", 60, 16'd60, 1'b0, 1'b0, 1'b1);
      pulse_period("min4", 4, 16'd4, 1'b1, 1'b0, 1'b1);
      pulse_period("max200", 200, 16'd200, 1'b0, 1'b0, 1'b1);
      pulse_period("hi_a", 20, 16'd20, 1'b1, 1'b0, 1'b1);
      pulse_period("hi_b", 20, 16'd20, 1'b1, 1'b1, 1'b1);

      // Carrier loss: hold positive; lock drops 200 cycles after the last pulse edge
      sine_in = POS;
      repeat (199) @(negedge clk);
      #1;
      check_eq("to_lock_before", carrier_lock, 1);
      @(negedge clk);
      #1;
      check_eq("to_lock_after", carrier_lock, 0);
      check_eq("to_data_hold", data_out, 1);
      check_eq("to_period_hold", period_out, 20);
      check_eq("to_class_hold", tone_class, 1);

      no_pulse_period("reacq", 20, 1'b0);
      pulse_period("reacq1", 20, 16'd20, 1'b1, 1'b1, 1'b0);
      pulse_period("reacq2", 20, 16'd20, 1'b1, 1'b1, 1'b1);

      // Reset mid-tone
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         sine_in = NEG;
      end
      reset = 1'b1;
      #1;
      check_eq("mid_rst_data", data_out, 0);
      check_eq("mid_rst_period", period_out, 0);
      check_eq("mid_rst_class", tone_class, 0);
      check_eq("mid_rst_lock", carrier_lock, 0);
      @(negedge clk);
      reset = 1'b0;
      no_pulse_period("rst_acq", 100, 1'b0);
      pulse_period("rst_p1", 100, 16'd100, 1'b0, 1'b0, 1'b0);
      pulse_period("rst_p2", 100, 16'd100, 1'b0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
